// File: rtl/min_sopc.sv
// min_sopc: five-stage in-order MIPS32-subset core (top0) with a read-only
// instruction ROM (inst_rom0). The pipeline has PC, IF/ID, ID/EX, EX/MEM and
// MEM/WB registers, with EX and MEM forwarding into ID, so it needs no stalls.
// Optional feature macro: MIN_SOPC_SHIFT_EN adds the SLL/SRL/SRA and
// SLLV/SRLV/SRAV shifts.

// Instruction ROM, 1024 words. Reads are combinational, and it returns 0 (NOP)
// while fetch is disabled.
module inst_rom (
  input  logic        ce,
  input  logic [9:0]  addr,
  output logic [31:0] inst
);
  logic [31:0] inst_mem [0:1023];

  assign inst = ce ? inst_mem[addr] : 32'h0;
endmodule

// Register file: 32x32, two combinational read ports and one write port.
// Reads are write-first. r0 is hard-wired to zero.
module regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] regs [0:31];

  // Write port; r0 is pinned to zero and writes to it are dropped
  always_ff @(posedge clk) begin
    regs[0] <= 32'h0;
    if (we && (waddr != 5'd0)) regs[waddr] <= wdata;
  end

  // Read port 1 with write-first bypass
  always_comb begin
    rdata1 = regs[raddr1];
    if (raddr1 == 5'd0) rdata1 = 32'h0;
    else if (we && (waddr == raddr1)) rdata1 = wdata;
  end

  // Read port 2 with write-first bypass
  always_comb begin
    rdata2 = regs[raddr2];
    if (raddr2 == 5'd0) rdata2 = 32'h0;
    else if (we && (waddr == raddr2)) rdata2 = wdata;
  end
endmodule

// Pipelined core. Control state (pc, ce, valid/write-enables) is reset
// asynchronously. Datapath registers are not reset, because the enables gate them.
module mips_core (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce,
  output logic [9:0]  rom_addr,
  input  logic [31:0] rom_inst
);
  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    OP_NOP, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_LUI, OP_SLL, OP_SRL, OP_SRA
  } aluop_t;

  function automatic logic [DATA_W-1:0] alu(input aluop_t op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] sb;
    sb = b;
    case (op)
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_XOR:  alu = a ^ b;
      OP_NOR:  alu = ~(a | b);
      OP_LUI:  alu = b;
      OP_SLL:  alu = b << a[4:0];
      OP_SRL:  alu = b >> a[4:0];
      OP_SRA:  alu = sb >>> a[4:0];
      default: alu = '0;
    endcase
  endfunction

  // Newest in-flight result wins: EX, then MEM, then register file.
  function automatic logic [DATA_W-1:0] fwd(input logic [4:0] ra,
                                            input logic [DATA_W-1:0] rf,
                                            input logic ex_we, input logic [4:0] ex_wa,
                                            input logic [DATA_W-1:0] ex_res,
                                            input logic mem_we, input logic [4:0] mem_wa,
                                            input logic [DATA_W-1:0] mem_res);
    if (ra == 5'd0)                    fwd = '0;
    else if (ex_we && (ex_wa == ra))   fwd = ex_res;
    else if (mem_we && (mem_wa == ra)) fwd = mem_res;
    else                               fwd = rf;
  endfunction

  logic [DATA_W-1:0] pc;
  logic              ce;
  logic              vld_p0;
  logic [DATA_W-1:0] inst_p0;
  logic              we_p1, we_p2, we_p3;
  aluop_t            op_p1;
  logic [DATA_W-1:0] a_p1, b_p1, res_p2, res_p3;
  logic [4:0]        waddr_p1, waddr_p2, waddr_p3;

  logic [DATA_W-1:0] rf_rs, rf_rt, rs_val, rt_val, res_ex;
  logic [DATA_W-1:0] a_id, b_id;
  aluop_t            op_id;
  logic [4:0]        waddr_id;
  logic              dec_we, we_id;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;

  // ---- PC stage ----
  // Fetch is enabled one edge after reset release, then PC steps by one word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ce <= 1'b0;
      pc <= '0;
    end else begin
      ce <= 1'b1;
      if (ce) pc <= pc + 32'd4;
    end
  end

  assign rom_ce   = ce;
  assign rom_addr = pc[11:2];

  // ---- IF/ID ----
  // Pipeline control: valid and write-enables, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0 <= 1'b0;
      we_p1  <= 1'b0;
      we_p2  <= 1'b0;
      we_p3  <= 1'b0;
    end else begin
      vld_p0 <= ce;
      we_p1  <= we_id;
      we_p2  <= we_p1;
      we_p3  <= we_p2;
    end
  end

  // Pipeline datapath registers (no reset needed; enables qualify them)
  always_ff @(posedge clk) begin
    inst_p0  <= rom_inst;
    op_p1    <= op_id;
    a_p1     <= a_id;
    b_p1     <= b_id;
    waddr_p1 <= waddr_id;
    res_p2   <= res_ex;
    waddr_p2 <= waddr_p1;
    res_p3   <= res_p2;
    waddr_p3 <= waddr_p2;
  end

  // ---- ID ----
  assign opcode = inst_p0[31:26];
  assign rs     = inst_p0[25:21];
  assign rt     = inst_p0[20:16];
  assign rd     = inst_p0[15:11];
  assign imm    = inst_p0[15:0];
  assign funct  = inst_p0[5:0];

  regfile regfile1 (
    .clk    (clk),
    .we     (we_p3),
    .waddr  (waddr_p3),
    .wdata  (res_p3),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rf_rs),
    .rdata2 (rf_rt)
  );

  assign rs_val = fwd(rs, rf_rs, we_p1, waddr_p1, res_ex, we_p2, waddr_p2, res_p2);
  assign rt_val = fwd(rt, rf_rt, we_p1, waddr_p1, res_ex, we_p2, waddr_p2, res_p2);

  // Decode: pick the ALU op, the operands and the destination. Unknown encodings are NOPs.
  always_comb begin
    op_id    = OP_NOP;
    dec_we   = 1'b0;
    waddr_id = rt;
    a_id     = rs_val;
    b_id     = {16'h0, imm};
    case (opcode)
      6'h00: begin
        waddr_id = rd;
        b_id     = rt_val;
        case (funct)
          6'h24: begin op_id = OP_AND; dec_we = 1'b1; end
          6'h25: begin op_id = OP_OR;  dec_we = 1'b1; end
          6'h26: begin op_id = OP_XOR; dec_we = 1'b1; end
          6'h27: begin op_id = OP_NOR; dec_we = 1'b1; end
`ifdef MIN_SOPC_SHIFT_EN
          6'h00: begin op_id = OP_SLL; dec_we = 1'b1; a_id = {27'd0, inst_p0[10:6]}; end
          6'h02: begin op_id = OP_SRL; dec_we = 1'b1; a_id = {27'd0, inst_p0[10:6]}; end
          6'h03: begin op_id = OP_SRA; dec_we = 1'b1; a_id = {27'd0, inst_p0[10:6]}; end
          6'h04: begin op_id = OP_SLL; dec_we = 1'b1; end
          6'h06: begin op_id = OP_SRL; dec_we = 1'b1; end
          6'h07: begin op_id = OP_SRA; dec_we = 1'b1; end
`endif
          default: ;
        endcase
      end
      6'h0C: begin op_id = OP_AND; dec_we = 1'b1; end
      6'h0D: begin op_id = OP_OR;  dec_we = 1'b1; end
      6'h0E: begin op_id = OP_XOR; dec_we = 1'b1; end
      6'h0F: begin op_id = OP_LUI; dec_we = 1'b1; b_id = {imm, 16'h0}; end
      default: ;
    endcase
    // r0 targets never enable a write, which also keeps them out of forwarding
    we_id = dec_we && vld_p0 && (waddr_id != 5'd0);
  end

  // ---- EX ----
  assign res_ex = alu(op_p1, a_p1, b_p1);

  // ---- MEM / WB ----
  // MEM is a pass-through. The write happens on the edge after MEM/WB.
endmodule

// System top: core plus instruction ROM
module min_sopc (
  input logic clk,
  input logic rst
);
  logic        rom_ce;
  logic [9:0]  rom_addr;
  logic [31:0] rom_inst;

  mips_core top0 (
    .clk      (clk),
    .rst      (rst),
    .rom_ce   (rom_ce),
    .rom_addr (rom_addr),
    .rom_inst (rom_inst)
  );

  inst_rom inst_rom0 (
    .ce   (rom_ce),
    .addr (rom_addr),
    .inst (rom_inst)
  );
endmodule

// File: tb/tb_min_sopc.sv
// Testbench for min_sopc. It has directed programs and randomized programs.
// An architectural ISA model tracks every register after each clock edge.
module tb_min_sopc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  min_sopc dut (.clk(clk), .rst(rst));

  int n_pass  = 0;
  int n_total = 0;
  int edge_n  = 0;
  logic [31:0] prog   [0:1023];
  logic [31:0] m_regs [0:31];
  bit          known  [0:31];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sa,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sa, fn};
  endfunction

  // Executes one instruction on the architectural state.
  task automatic model_exec(input logic [31:0] ins);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sa, dst;
    logic [15:0] imm;
    logic [31:0] a, b, v;
    bit wr;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    sa = ins[10:6];  fn = ins[5:0];   imm = ins[15:0];
    a = m_regs[rs]; b = m_regs[rt]; v = 32'h0; wr = 1'b0; dst = rt;
    case (op)
      6'h00: begin
        dst = rd;
        case (fn)
          6'h24: begin v = a & b;    wr = 1'b1; end
          6'h25: begin v = a | b;    wr = 1'b1; end
          6'h26: begin v = a ^ b;    wr = 1'b1; end
          6'h27: begin v = ~(a | b); wr = 1'b1; end
`ifdef MIN_SOPC_SHIFT_EN
          6'h00: begin v = b << sa; wr = 1'b1; end
          6'h02: begin v = b >> sa; wr = 1'b1; end
          6'h03: begin v = (b >> sa) | (b[31] ? ~(32'hFFFF_FFFF >> sa) : 32'h0); wr = 1'b1; end
          6'h04: begin v = b << a[4:0]; wr = 1'b1; end
          6'h06: begin v = b >> a[4:0]; wr = 1'b1; end
          6'h07: begin v = (b >> a[4:0]) | (b[31] ? ~(32'hFFFF_FFFF >> a[4:0]) : 32'h0); wr = 1'b1; end
`endif
          default: ;
        endcase
      end
      6'h0C: begin v = a & {16'h0, imm}; wr = 1'b1; end
      6'h0D: begin v = a | {16'h0, imm}; wr = 1'b1; end
      6'h0E: begin v = a ^ {16'h0, imm}; wr = 1'b1; end
      6'h0F: begin v = {imm, 16'h0};     wr = 1'b1; end
      default: ;
    endcase
    if (wr && dst != 5'd0) begin
      m_regs[dst] = v;
      known[dst]  = 1'b1;
    end
  endtask

  task automatic compare_all(input string pfx);
    for (int i = 0; i < 32; i++)
      if (known[i]) check($sformatf("%s r%0d", pfx, i), dut.top0.regfile1.regs[i], m_regs[i]);
  endtask

  task automatic load(input logic [31:0] words [$]);
    for (int i = 0; i < 1024; i++) begin
      prog[i] = (i < words.size()) ? words[i] : 32'h0;
      dut.inst_rom0.inst_mem[i] = prog[i];
    end
  endtask

  task automatic hold_reset(input int cycles);
    rst = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    edge_n = 0;
  endtask

  // One edge: instruction k lands in the model on edge 6+k, then full compare.
  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
    if (edge_n >= 6) model_exec(prog[edge_n - 6]);
    compare_all($sformatf("e%0d", edge_n));
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) step();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0] rs, rt, rd, sa;
    logic [31:0] r;
    int k;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    sa = 5'($urandom_range(0, 31));
    r  = $urandom();
    k  = $urandom_range(0, 15);
    if (k < 4)       return enc_r(rs, rt, rd, 5'd0, 6'h24 + 6'(k));
    else if (k < 8)  return enc_i(6'h0C + 6'(k - 4), rs, rt, r[15:0]);
    else if (k == 8) return enc_r(rs, rt, rd, sa, 6'h00);
    else if (k == 9) return enc_r(rs, rt, rd, sa, 6'h02);
    else if (k == 10) return enc_r(rs, rt, rd, sa, 6'h03);
    else if (k == 11) return enc_r(rs, rt, rd, 5'd0, 6'h04 + 6'(2 * (r[1:0] % 2'd2)));
    else if (k == 12) return enc_r(rs, rt, rd, 5'd0, 6'h07);
    else if (k == 13) return 32'h0;
    else if (k == 14) return enc_r(rs, rt, rd, 5'd0, 6'h20);
    else             return {6'h23, r[25:0]};
  endfunction

  initial begin
    #500000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] q [$];
    for (int i = 0; i < 32; i++) begin known[i] = 1'b0; m_regs[i] = 32'h0; end
    known[0] = 1'b1;

    // Reset state
    hold_reset(3);
    check("rst ce", {31'd0, dut.top0.ce}, 32'h0);
    check("rst pc", dut.top0.pc, 32'h0);
    check("rst we_p3", {31'd0, dut.top0.we_p3}, 32'h0);

    // Seed every register with a known value
    q = {};
    for (int n = 1; n < 32; n++) q.push_back(enc_i(6'h0D, 5'd0, 5'(n), 16'hA500 + 16'(n)));
    load(q);
    release_reset();
    step();
    check("e1 ce", {31'd0, dut.top0.ce}, 32'h1);
    check("e1 pc", dut.top0.pc, 32'h0);
    step();
    check("e2 pc", dut.top0.pc, 32'h4);
    run_to(31 + 7);

    // Logic sequence
    hold_reset(2);
    q = {enc_i(6'h0F, 5'd0, 5'd1, 16'h0101), enc_i(6'h0D, 5'd1, 5'd1, 16'h0101),
         enc_i(6'h0D, 5'd1, 5'd2, 16'h1100), enc_r(5'd1, 5'd2, 5'd1, 5'd0, 6'h25),
         enc_i(6'h0C, 5'd1, 5'd3, 16'h0000), enc_r(5'd3, 5'd1, 5'd1, 5'd0, 6'h24),
         enc_i(6'h0D, 5'd0, 5'd4, 16'hFF00), enc_r(5'd4, 5'd0, 5'd1, 5'd0, 6'h25),
         enc_r(5'd4, 5'd0, 5'd1, 5'd0, 6'h27)};
    load(q);
    release_reset();
    run_to(6);
    check("logic e6 r1", dut.top0.regfile1.regs[1], 32'h0101_0000);
    run_to(7);
    check("logic e7 r1", dut.top0.regfile1.regs[1], 32'h0101_0101);
    run_to(9);
    check("logic e9 r1", dut.top0.regfile1.regs[1], 32'h0101_1101);
    run_to(16);
    check("logic r1", dut.top0.regfile1.regs[1], 32'hFFFF_00FF);
    check("logic r2", dut.top0.regfile1.regs[2], 32'h0101_1101);
    check("logic r3", dut.top0.regfile1.regs[3], 32'h0);
    check("logic r4", dut.top0.regfile1.regs[4], 32'h0000_FF00);

    // Latency of a single instruction
    hold_reset(2);
    q = {enc_i(6'h0D, 5'd0, 5'd5, 16'h1234)};
    load(q);
    release_reset();
    run_to(5);
    check("lat e5 r5", dut.top0.regfile1.regs[5], 32'h0000_A505);
    step();
    check("lat e6 r5", dut.top0.regfile1.regs[5], 32'h0000_1234);

    // r0 immutability
    hold_reset(2);
    q = {enc_i(6'h0D, 5'd0, 5'd0, 16'hFFFF), enc_r(5'd0, 5'd0, 5'd6, 5'd0, 6'h25)};
    load(q);
    release_reset();
    run_to(9);
    check("r0 r0", dut.top0.regfile1.regs[0], 32'h0);
    check("r0 r6", dut.top0.regfile1.regs[6], 32'h0);

    // XORI / XOR across a NOP
    hold_reset(2);
    q = {enc_i(6'h0D, 5'd0, 5'd7, 16'h00F0), 32'h0, enc_i(6'h0E, 5'd7, 5'd7, 16'h0FF0),
         enc_r(5'd7, 5'd7, 5'd8, 5'd0, 6'h26)};
    load(q);
    release_reset();
    run_to(11);
    check("xor r7", dut.top0.regfile1.regs[7], 32'h0000_0F00);
    check("xor r8", dut.top0.regfile1.regs[8], 32'h0);

    // Shifts (NOPs unless the feature is built in)
    hold_reset(2);
    q = {enc_i(6'h0D, 5'd0, 5'd1, 16'h8000), enc_r(5'd0, 5'd1, 5'd2, 5'd16, 6'h00),
         enc_r(5'd0, 5'd2, 5'd3, 5'd4, 6'h03)};
    load(q);
    release_reset();
    run_to(10);
`ifdef MIN_SOPC_SHIFT_EN
    check("shift r2", dut.top0.regfile1.regs[2], 32'h8000_0000);
    check("shift r3", dut.top0.regfile1.regs[3], 32'hF800_0000);
`else
    check("shift r2", dut.top0.regfile1.regs[2], 32'h0101_1101);
    check("shift r3", dut.top0.regfile1.regs[3], 32'h0);
`endif

    // Randomized program interrupted by a mid-run reset
    hold_reset(2);
    q = {};
    for (int i = 0; i < 60; i++) q.push_back(rand_inst());
    load(q);
    release_reset();
    run_to(20);
    rst = 1'b0;
    #1;
    check("mid ce", {31'd0, dut.top0.ce}, 32'h0);
    check("mid pc", dut.top0.pc, 32'h0);
    check("mid we_p1", {31'd0, dut.top0.we_p1}, 32'h0);
    check("mid we_p2", {31'd0, dut.top0.we_p2}, 32'h0);
    check("mid we_p3", {31'd0, dut.top0.we_p3}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      compare_all($sformatf("inrst%0d", c));
    end
    release_reset();
    run_to(60 + 7);

    // A second random program without interruption
    hold_reset(2);
    q = {};
    for (int i = 0; i < 80; i++) q.push_back(rand_inst());
    load(q);
    release_reset();
    run_to(80 + 7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/min_sopc.md
# min_sopc

Minimal system-on-programmable-chip wrapping a 5-stage, in-order, MIPS32-subset pipelined CPU core (`top0`) and a read-only instruction memory (`inst_rom0`). It is the top of the CPU design and the unit verified by program-level benches. There is no data memory. Benches preload the ROM and observe architectural state through hierarchical register-file references.

## Interface
- No parameters. Depths and widths below are fixed.
- `clk` input 1: single system clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-low reset. Asserted (0) clears the pipeline.
- No other ports.
- The following hierarchical names are part of the interface and must exist exactly:
  - `top0.regfile1.regs[0..31]`: 32×32-bit register array.
  - `inst_rom0.inst_mem[0..1023]`: 32-bit words, loadable with `$readmemh`.

## Operation
- Pipeline stages: PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, then register-file write.
- PC register:
  - Held at 0 with `ce`=0 during reset.
  - First rising edge after release sets `ce`=1 with PC=0.
  - PC then advances by 4 per cycle. No branches.
- ROM:
  - Combinational read of `inst_mem[pc[11:2]]`.
  - Returns 0 when `ce`=0.
- Decoded instructions:
  - R-type, funct field: AND (0x24), OR (0x25), XOR (0x26), NOR (0x27). Result goes to rd.
  - I-type, opcode field: ANDI (0x0C), ORI (0x0D), XORI (0x0E), LUI (0x0F). Result goes to rt.
- Immediates are zero-extended. LUI result is {imm,16'h0}.
- Any other encoding, including 0x00000000, is a NOP: no register write.
- Register 0 reads as 0 and writes to it are discarded.
- Register file:
  - Two combinational read ports and one write port.
  - A read of the register being written in the same cycle returns the new data (write-first).
  - Registers 1–31 are not reset; they are X until first written.
- Forwarding into ID:
  - EX-stage result has priority, then MEM-stage result, then the register file.
  - Back-to-back dependent instructions therefore need no stalls.
- No stall or flush logic. One instruction retires per cycle.
- Reset in mid-operation:
  - All pipeline registers clear to NOP (write-enable 0) and PC returns to 0.
  - Register contents are retained.

## Timing
- Instruction k (0-based, at ROM word k) writes its destination on the (6+k)-th rising edge after `rst` deasserts.
- The new value is visible in `regs[]` immediately after that edge.
- ID-to-WB latency is 4 cycles. Throughput is 1 instruction per cycle.
- `rst` low asynchronously forces PC=0, `ce`=0 and all stage write-enables to 0 without waiting for a clock edge.

## Configuration
- `MIN_SOPC_SHIFT_EN`:
  - Defined: the core also executes SLL, SRL, SRA (funct 0x00/0x02/0x03, shift amount from `sa`) and SLLV, SRLV, SRAV (funct 0x04/0x06/0x07, shift amount from rs[4:0]). These use the same forwarding and the same latency as the logic operations.
  - Not defined: these encodings decode as NOP. 0x00000000 is a NOP either way.

## Test plan
- Logic sequence: preload lui r1,0x0101; ori r1,r1,0x0101; ori r2,r1,0x1100; or r1,r1,r2; andi r3,r1,0; and r1,r3,r1; ori r4,r0,0xFF00; or r1,r4,r0; nor r1,r4,r0. Release reset. Required register values on each successive post-edge sample:
  - r1 = 0x01010000
  - r1 = 0x01010101
  - r2 = 0x01011101
  - r1 = 0x01011101
  - r3 = 0x00000000
  - r1 = 0x00000000
  - r4 = 0x0000FF00
  - r1 = 0x0000FF00
  - r1 = 0xFFFF00FF
  - Registers not yet written stay X.
- Latency: single `ori r5,r0,0x1234` at word 0 -> r5 changes exactly at the 6th rising edge after `rst` release and not before.
- r0 immutability: `ori r0,r0,0xFFFF` followed by `or r6,r0,r0` -> r0 stays 0 and r6 = 0.
- XORI/XOR and NOP: `ori r7,r0,0x00F0`, `nop`, `xori r7,r7,0x0FF0`, `xor r8,r7,r7` -> r7 = 0x00000F00, then r8 = 0.
- Mid-run reset: assert `rst`=0 for 3 cycles while the pipeline is full, then release -> no register writes occur during reset, register values are retained, and execution restarts from word 0 with 6-edge latency.
- With `MIN_SOPC_SHIFT_EN` defined: `ori r1,r0,0x8000`, `sll r2,r1,16`, `sra r3,r2,4` -> r2 = 0x80000000, r3 = 0xF8000000. Without the macro, r2 and r3 remain X.
